// File: rtl/uart_pkg.sv
// Shared constants and intake FSM encoding for the UART receive buffer.
package uart_pkg;
   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_CLEAR   = 2'd2
   } rx_state_t;
endpackage

// File: rtl/uart_fifo_ram.sv
// Byte storage: one synchronous write port, one registered read port.
// The array itself is never reset; only the read register is.
module uart_fifo_ram
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [UART_DATA_W-1:0]     wdata,
   input  logic                       re,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [UART_DATA_W-1:0]     rdata
);
   logic [UART_DATA_W-1:0] r_mem [DEPTH];
   logic [UART_DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
   end

   // Read-before-write: a same-address write lands after the old byte is taken.
   always_ff @(posedge clk) begin
      if (rst)     r_rdata <= '0;
      else if (re) r_rdata <= r_mem[raddr];
   end

   assign rdata = r_rdata;
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: handshake intake FSM feeding a DEPTH-byte FIFO.
// Optional sticky drop flag enabled by macro UART_RX_FIFO_OVERFLOW_EN.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                        full_clk,
   input  logic                        rst,
   input  logic [UART_DATA_W-1:0]      recv_out,
   input  logic                        get_recv,
   output logic                        set_recv_clear,
   input  logic                        rd_en,
   output logic [UART_DATA_W-1:0]      data_out,
   output logic                        rd_valid,
   output logic                        empty,
   output logic                        full,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        overflow,
   input  logic                        clr_overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   rx_state_t      r_state;
   logic           r_clear;
   logic           r_rd_valid;
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;

   logic w_rd;
   logic w_capture;
   logic w_wr;
   logic w_drop;

   assign empty     = (r_count == '0);
   assign full      = (r_count == CW'(DEPTH));
   assign w_rd      = rd_en & ~empty;
   assign w_capture = (r_state == ST_CAPTURE);
   // A read in the capture cycle frees a slot, so a full buffer still accepts.
   assign w_wr      = w_capture & (~full | w_rd);
   assign w_drop    = w_capture & ~w_wr;

   always_ff @(posedge full_clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_clear <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_clear <= 1'b0;
               if (get_recv) r_state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               r_clear <= get_recv;
               r_state <= ST_CLEAR;
            end
            ST_CLEAR: begin
               if (get_recv) begin
                  r_clear <= 1'b1;
               end else begin
                  r_clear <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_clear <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge full_clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_rd;
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   uart_fifo_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (full_clk),
      .rst   (rst),
      .we    (w_wr),
      .waddr (r_wr_ptr),
      .wdata (recv_out),
      .re    (w_rd),
      .raddr (r_rd_ptr),
      .rdata (data_out)
   );

`ifdef UART_RX_FIFO_OVERFLOW_EN
   logic r_overflow;

   // A new drop takes priority over a same-cycle clear.
   always_ff @(posedge full_clk) begin
      if (rst)               r_overflow <= 1'b0;
      else if (w_drop)       r_overflow <= 1'b1;
      else if (clr_overflow) r_overflow <= 1'b0;
   end

   assign overflow = r_overflow;
`else
   logic w_unused;
   assign w_unused = clr_overflow ^ w_drop;
   assign overflow = 1'b0;
`endif

   assign set_recv_clear = r_clear;
   assign rd_valid       = r_rd_valid;
   assign count          = r_count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_FIFO_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic          full_clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    recv_out = '0;
   logic          get_recv = 1'b0;
   logic          set_recv_clear;
   logic          rd_en = 1'b0;
   logic [7:0]    data_out;
   logic          rd_valid;
   logic          empty;
   logic          full;
   logic [CW-1:0] count;
   logic          overflow;
   logic          clr_overflow = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] q[$];
   bit         ovf_m;
   logic [7:0] last_d;

   uart_rx_fifo #(.DEPTH(DEPTH)) dut (
      .full_clk       (full_clk),
      .rst            (rst),
      .recv_out       (recv_out),
      .get_recv       (get_recv),
      .set_recv_clear (set_recv_clear),
      .rd_en          (rd_en),
      .data_out       (data_out),
      .rd_valid       (rd_valid),
      .empty          (empty),
      .full           (full),
      .count          (count),
      .overflow       (overflow),
      .clr_overflow   (clr_overflow)
   );

   always #5 full_clk = ~full_clk;

   // Reference behaviour of one byte arrival, optionally with a CPU read in the same cycle.
   function automatic void model_arrive(input logic [7:0] b, input bit rd,
                                        output bit exp_v);
      exp_v = rd && (q.size() > 0);
      if (exp_v) last_d = q.pop_front();
      if (q.size() < DEPTH) q.push_back(b);
      else ovf_m = 1'b1;
   endfunction

   function automatic void model_read(output bit exp_v);
      exp_v = (q.size() > 0);
      if (exp_v) last_d = q.pop_front();
   endfunction

   function automatic bit exp_ovf();
      return OVF_EN ? ovf_m : 1'b0;
   endfunction

   task automatic do_reset();
      rst = 1'b1; get_recv = 1'b0; rd_en = 1'b0; clr_overflow = 1'b0;
      repeat (2) @(negedge full_clk);
      rst = 1'b0;
      q.delete(); ovf_m = 1'b0; last_d = 8'h00;
   endtask

   // One full get_recv handshake; rd/clr are raised for exactly the capture cycle.
   task automatic drive_byte(input logic [7:0] b, input int hold, input bit rd, input bit clr,
                             output bit ok, output bit got_v, output logic [7:0] got_d);
      recv_out = b; get_recv = 1'b1;
      @(negedge full_clk);
      rd_en = rd; clr_overflow = clr;
      @(negedge full_clk);
      rd_en = 1'b0; clr_overflow = 1'b0;
      got_v = rd_valid; got_d = data_out;
      repeat (hold) @(negedge full_clk);
      for (int i = 0; i < 10 && !set_recv_clear; i++) @(negedge full_clk);
      ok = set_recv_clear;
      get_recv = 1'b0;
      @(negedge full_clk);
      ok = ok && !set_recv_clear;
      @(negedge full_clk);
   endtask

   task automatic read_byte(output bit got_v, output logic [7:0] got_d);
      rd_en = 1'b1;
      @(negedge full_clk);
      rd_en = 1'b0;
      got_v = rd_valid; got_d = data_out;
   endtask

   task automatic test_reset();
      logic [CW+13:0] obs, exp;
      rst = 1'b1;
      repeat (2) @(negedge full_clk);
      obs = {count, empty, full, data_out, rd_valid, set_recv_clear, overflow};
      exp = {CW'(0), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp) begin
         n_fail++; $display("FAIL reset_state: got %h expected %h", obs, exp);
      end
      do_reset();
   endtask

   task automatic test_long_hold();
      do_reset();
      recv_out = 8'h41; get_recv = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge full_clk);
         if (k >= 2) begin
            n_checks++;
            if (set_recv_clear !== 1'b1) begin
               n_fail++; $display("FAIL hold_clear_high k=%0d: got %b expected 1", k, set_recv_clear);
            end
         end
      end
      n_checks++;
      if (count !== CW'(1)) begin
         n_fail++; $display("FAIL hold_count: got %0d expected 1", count);
      end
      get_recv = 1'b0;
      @(negedge full_clk);
      n_checks++;
      if (set_recv_clear !== 1'b0) begin
         n_fail++; $display("FAIL hold_clear_fall: got %b expected 0", set_recv_clear);
      end
      repeat (3) @(negedge full_clk);
      n_checks++;
      if (count !== CW'(1)) begin
         n_fail++; $display("FAIL hold_count_after: got %0d expected 1", count);
      end
   endtask

   task automatic test_fill_overflow();
      bit ok, v, ev; logic [7:0] d;
      do_reset();
      for (int b = 1; b <= 17; b++) begin
         drive_byte(8'(b), 0, 1'b0, 1'b0, ok, v, d);
         model_arrive(8'(b), 1'b0, ev);
         n_checks++;
         if (!ok || count !== CW'(q.size())) begin
            n_fail++; $display("FAIL fill_count b=%0d: got %0d ok=%b expected %0d", b, count, ok, q.size());
         end
         if (b == 16) begin
            n_checks++;
            if (full !== 1'b1 || overflow !== 1'b0) begin
               n_fail++; $display("FAIL fill_full: got full=%b ovf=%b expected 1/0", full, overflow);
            end
         end
      end
      n_checks++;
      if (overflow !== exp_ovf() || full !== 1'b1) begin
         n_fail++; $display("FAIL drop_overflow: got ovf=%b full=%b expected %b/1", overflow, full, exp_ovf());
      end
   endtask

   task automatic test_drain();
      bit v, ev; logic [7:0] d;
      for (int i = 0; i < DEPTH; i++) begin
         read_byte(v, d);
         model_read(ev);
         n_checks++;
         if (v !== ev || d !== last_d) begin
            n_fail++; $display("FAIL drain_%0d: got v=%b d=%h expected v=%b d=%h", i, v, d, ev, last_d);
         end
      end
      @(negedge full_clk);
      n_checks++;
      if (empty !== 1'b1 || rd_valid !== 1'b0) begin
         n_fail++; $display("FAIL drain_empty: got empty=%b rv=%b expected 1/0", empty, rd_valid);
      end
      read_byte(v, d);
      n_checks++;
      if (v !== 1'b0 || d !== last_d || count !== CW'(0)) begin
         n_fail++; $display("FAIL read_when_empty: got v=%b d=%h cnt=%0d expected 0/%h/0", v, d, count, last_d);
      end
   endtask

   task automatic test_simul_full();
      bit ok, v, ev; logic [7:0] d, b;
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom);
         drive_byte(b, 0, 1'b0, 1'b0, ok, v, d);
         model_arrive(b, 1'b0, ev);
      end
      b = 8'($urandom);
      drive_byte(b, 1, 1'b1, 1'b0, ok, v, d);
      model_arrive(b, 1'b1, ev);
      n_checks++;
      if (!ok || v !== ev || d !== last_d || count !== CW'(DEPTH) || overflow !== 1'b0) begin
         n_fail++; $display("FAIL simul_full: got v=%b d=%h cnt=%0d ovf=%b expected %b/%h/%0d/0",
                            v, d, count, overflow, ev, last_d, DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) begin
         read_byte(v, d);
         model_read(ev);
         n_checks++;
         if (v !== ev || d !== last_d) begin
            n_fail++; $display("FAIL simul_drain_%0d: got %b/%h expected %b/%h", i, v, d, ev, last_d);
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      logic [CW+13:0] obs, exp;
      bit ok, v, ev; logic [7:0] d;
      do_reset();
      drive_byte(8'h33, 0, 1'b0, 1'b0, ok, v, d);
      read_byte(v, d);
      drive_byte(8'h34, 0, 1'b0, 1'b0, ok, v, d);
      recv_out = 8'h5A; get_recv = 1'b1;
      for (int i = 0; i < 10 && !set_recv_clear; i++) @(negedge full_clk);
      rst = 1'b1;
      @(negedge full_clk);
      obs = {count, empty, full, data_out, rd_valid, set_recv_clear, overflow};
      exp = {CW'(0), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp) begin
         n_fail++; $display("FAIL reset_mid_clear: got %h expected %h", obs, exp);
      end
      rst = 1'b0;
      q.delete(); ovf_m = 1'b0; last_d = 8'h00;
      for (int i = 0; i < 10 && !set_recv_clear; i++) @(negedge full_clk);
      ok = set_recv_clear;
      get_recv = 1'b0;
      repeat (2) @(negedge full_clk);
      model_arrive(8'h5A, 1'b0, ev);
      n_checks++;
      if (!ok || count !== CW'(1)) begin
         n_fail++; $display("FAIL rearm_write: got cnt=%0d ok=%b expected 1/1", count, ok);
      end
      read_byte(v, d);
      model_read(ev);
      n_checks++;
      if (v !== ev || d !== last_d) begin
         n_fail++; $display("FAIL rearm_data: got %b/%h expected %b/%h", v, d, ev, last_d);
      end
   endtask

   task automatic test_clr_overflow();
      bit ok, v, ev; logic [7:0] d;
      do_reset();
      for (int i = 0; i <= DEPTH; i++) begin
         drive_byte(8'(i + 8'h80), 0, 1'b0, 1'b0, ok, v, d);
         model_arrive(8'(i + 8'h80), 1'b0, ev);
      end
      clr_overflow = 1'b1;
      @(negedge full_clk);
      clr_overflow = 1'b0;
      ovf_m = 1'b0;
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++; $display("FAIL clr_overflow: got %b expected 0", overflow);
      end
      drive_byte(8'hEE, 0, 1'b0, 1'b1, ok, v, d);
      model_arrive(8'hEE, 1'b0, ev);
      n_checks++;
      if (!ok || overflow !== exp_ovf() || count !== CW'(DEPTH)) begin
         n_fail++; $display("FAIL set_beats_clr: got ovf=%b cnt=%0d expected %b/%0d", overflow, count, exp_ovf(), DEPTH);
      end
   endtask

   task automatic test_random();
      bit ok, v, ev, rd; logic [7:0] d, b;
      int op;
      do_reset();
      for (int n = 0; n < 250; n++) begin
         op = $urandom_range(0, 4);
         if (op <= 2) begin
            b  = 8'($urandom);
            rd = ($urandom_range(0, 2) == 0);
            drive_byte(b, $urandom_range(0, 3), rd, 1'b0, ok, v, d);
            model_arrive(b, rd, ev);
         end else begin
            read_byte(v, d);
            model_read(ev);
            ok = 1'b1;
         end
         n_checks++;
         if (!ok || v !== ev || d !== last_d || count !== CW'(q.size()) ||
             empty !== (q.size() == 0) || full !== (q.size() == DEPTH) || overflow !== exp_ovf()) begin
            n_fail++;
            $display("FAIL random_%0d op=%0d: got ok=%b v=%b d=%h cnt=%0d e=%b f=%b ovf=%b expected v=%b d=%h cnt=%0d ovf=%b",
                     n, op, ok, v, d, count, empty, full, overflow, ev, last_d, q.size(), exp_ovf());
         end
      end
   endtask

   initial begin
      test_reset();
      test_long_hold();
      test_fill_overflow();
      test_drain();
      test_simul_full();
      test_reset_mid_clear();
      test_clr_overflow();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, receive buffer depth in bytes; power of two, 2..256.
REQ-002 SHALL have port full_clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port recv_out  input  8  received byte from the UART receiver.
REQ-005 SHALL have port get_recv  input  1  UART byte-ready level; held high until cleared.
REQ-006 SHALL have port set_recv_clear  output  1  clear request to the UART receiver.
REQ-007 SHALL have port rd_en  input  1  CPU read strobe, one byte per high cycle.
REQ-008 SHALL have port data_out  output  8  byte read from the buffer.
REQ-009 SHALL have port rd_valid  output  1  one-cycle pulse; data_out is valid.
REQ-010 SHALL have port empty  output  1  buffer holds zero bytes.
REQ-011 SHALL have port full  output  1  buffer holds DEPTH bytes.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  bytes currently held.
REQ-013 SHALL have port overflow  output  1  sticky dropped-byte flag.
REQ-014 SHALL have port clr_overflow  input  1  clears overflow.

Function
REQ-015 SHALL run intake FSM states IDLE, CAPTURE, CLEAR.
REQ-016 IDLE SHALL go to CAPTURE on the cycle after get_recv is sampled high.
REQ-017 CAPTURE SHALL last one cycle: write recv_out at wr_ptr if not full or if a read is accepted that cycle; otherwise drop the byte; then go to CLEAR.
REQ-018 CLEAR SHALL drive set_recv_clear=1 while get_recv=1 and return to IDLE with set_recv_clear=0 on the first cycle get_recv samples 0.
REQ-019 set_recv_clear SHALL be registered and 0 in IDLE and CAPTURE.
REQ-020 Each get_recv assertion SHALL produce exactly one write attempt, regardless of how long the assertion lasts.
REQ-021 A read SHALL be accepted when rd_en=1 and empty=0; rd_en while empty SHALL be ignored, with no state change.
REQ-022 An accepted read SHALL update data_out and pulse rd_valid on the next cycle (1-cycle latency); data_out SHALL hold its value otherwise.
REQ-023 Pointers SHALL wrap modulo DEPTH; count SHALL be +1 on write only, -1 on read only, and unchanged on simultaneous write and read.
REQ-024 empty and full SHALL derive from registered count, valid in the same cycle.
REQ-025 A simultaneous write and read when full SHALL accept both; count stays DEPTH.
REQ-026 A simultaneous write and read when empty SHALL accept only the write.

Reset
REQ-027 rst SHALL force FSM=IDLE, pointers=0, count=0, empty=1, full=0, data_out=0, rd_valid=0, set_recv_clear=0, overflow=0.
REQ-028 rst mid-CLEAR SHALL abandon the handshake; if get_recv is still high after reset, IDLE SHALL treat it as a new byte.
REQ-029 Buffer storage SHALL NOT require a reset.

Configuration
REQ-030 With macro UART_RX_FIFO_OVERFLOW_EN defined, a dropped byte SHALL set overflow on the next cycle; overflow SHALL remain set until clr_overflow or rst, and set SHALL win over a same-cycle clr_overflow.
REQ-031 Without UART_RX_FIFO_OVERFLOW_EN, overflow SHALL be constant 0, clr_overflow SHALL be ignored, and dropped bytes SHALL be discarded silently.

Structure
REQ-032 Package uart_pkg SHALL hold UART_DATA_W=8 and the intake FSM state enum.
REQ-033 Storage SHALL be a sub-module uart_fifo_ram: DEPTH x 8, one synchronous write port and one registered read port.

Verification
REQ-034 Hold get_recv high 12 cycles with recv_out=8'h41 -> exactly one write, count=1, set_recv_clear high until get_recv falls.
REQ-035 Push 8'h01..8'h10 with DEPTH=16 -> full=1, count=16; 8'h11 dropped; overflow=1 when the macro is defined, 0 when it is not.
REQ-036 Issue 16 rd_en pulses after the fill -> data_out 8'h01..8'h10 in order, each one cycle after rd_en; then empty=1; a further rd_en gives no rd_valid.
REQ-037 Full buffer, CAPTURE in the same cycle as rd_en -> both accepted, count stays 16, next read returns the old head byte.
REQ-038 Assert rst during CLEAR with get_recv high -> all outputs at reset values; one new write occurs after rst falls.
REQ-039 Assert clr_overflow in the same cycle as a new drop -> overflow stays 1.
